rom_fetch_ctrl: RTL and testbench



---
 rtl/rom_fetch_ctrl_pkg.sv | 8 +
 rtl/rom_fetch_ctrl_if.sv | 24 ++
 rtl/rom_fetch_ctrl.sv | 74 +++++++
 tb/tb_rom_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_ctrl_pkg.sv
// rom_pkg: shared widths, latency limit and fetch FSM states for the ROM datapath
package rom_pkg;
  localparam int ENC_W       = 39;
  localparam int DATA_W      = 32;
  localparam int ROM_LAT_MAX = 4;
  localparam int CNT_W       = $clog2(ROM_LAT_MAX);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} fetch_state_e;
endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// rom_fetch_ctrl_if: request, ROM and encoded-word channels of the fetch controller
interface rom_fetch_ctrl_if #(parameter int ADDR_W = 10, parameter int LEN_W = 4);
  import rom_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [ENC_W-1:0]  rom_rdata;
  logic              enc_valid;
  logic              enc_ready;
  logic [ENC_W-1:0]  enc_data;
  logic [ADDR_W-1:0] enc_addr;
  logic              enc_last;
  modport master (
    input  req_valid, req_addr, req_len, rom_rdata, enc_ready,
    output req_ready, rom_en, rom_addr, enc_valid, enc_data, enc_addr, enc_last
  );
  modport slave (
    output req_valid, req_addr, req_len, rom_rdata, enc_ready,
    input  req_ready, rom_en, rom_addr, enc_valid, enc_data, enc_addr, enc_last
  );
endinterface

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: issues single/burst ROM reads and hands each encoded word to the decoder
module rom_fetch_ctrl
  import rom_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LEN_W   = 4,
  parameter int ROM_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  rom_fetch_ctrl_if.master bus,
  output logic         busy
);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ROM_LAT - 1);
  fetch_state_e      r_state, w_next;
  logic [ADDR_W-1:0] r_cur_addr, r_enc_addr;
  logic [LEN_W-1:0]  r_remain;
  logic [CNT_W-1:0]  r_lat_cnt;
  logic [ENC_W-1:0]  r_enc_data;
  logic              r_enc_last;
  logic              w_accept, w_sample, w_advance;
  assign w_accept  = r_state == IDLE && bus.req_valid;
  assign w_sample  = r_state == WAIT && r_lat_cnt == '0;
  assign w_advance = r_state == HOLD && bus.enc_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = w_sample ? HOLD : WAIT;
      HOLD:    w_next = !w_advance ? HOLD : (r_remain == '0 ? IDLE : ISSUE);
      default: w_next = IDLE;
    endcase
  end
  // rom_rdata is only looked at in the sampling cycle, so stray X never reaches enc_data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur_addr <= '0;
      r_remain   <= '0;
      r_lat_cnt  <= '0;
      r_enc_data <= '0;
      r_enc_addr <= '0;
      r_enc_last <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cur_addr <= bus.req_addr;
        r_remain   <= bus.req_len;
      end
      if (r_state == ISSUE) r_lat_cnt <= LAT_INIT;
      if (r_state == WAIT)  r_lat_cnt <= r_lat_cnt - 1'b1;
      if (w_sample) begin
        r_enc_data <= bus.rom_rdata;
        r_enc_addr <= r_cur_addr;
        r_enc_last <= r_remain == '0;
      end
      if (w_advance && r_remain != '0) begin
        r_remain   <= r_remain - 1'b1;
        r_cur_addr <= r_cur_addr + 1'b1;
      end
    end
  end
  assign bus.req_ready = rst_n && r_state == IDLE;
  assign bus.rom_en    = r_state == ISSUE;
  assign bus.rom_addr  = r_cur_addr;
  assign bus.enc_valid = r_state == HOLD;
  assign bus.enc_data  = r_enc_data;
  assign bus.enc_addr  = r_enc_addr;
  assign bus.enc_last  = r_enc_last;
  assign busy          = r_state != IDLE;
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb_rom_fetch_ctrl: directed checks of the fetch controller at ROM latency 1 and 4
module tb_rom_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy1, busy4;
  int pass_cnt = 0;
  int tot_cnt = 0;
  logic [3:0]       v1 = '0, v4 = '0;
  logic [3:0][38:0] p1, p4;
  rom_fetch_ctrl_if #(.ADDR_W(10), .LEN_W(4)) if1 ();
  rom_fetch_ctrl_if #(.ADDR_W(10), .LEN_W(4)) if4 ();
  rom_fetch_ctrl #(.ADDR_W(10), .LEN_W(4), .ROM_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1));
  rom_fetch_ctrl #(.ADDR_W(10), .LEN_W(4), .ROM_LAT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4), .busy(busy4));
  always #5 clk = ~clk;
  function automatic logic [38:0] rom_word(input logic [9:0] a);
    return a == 10'h005 ? 39'h12_3456_789A : {5'h0a, a, ~a, a, 4'h3};
  endfunction
  // ROM models: data valid only ROM_LAT cycles after rom_en, X otherwise
  always @(posedge clk) begin
    v1 <= {v1[2:0], if1.rom_en};
    p1 <= {p1[2:0], rom_word(if1.rom_addr)};
    v4 <= {v4[2:0], if4.rom_en};
    p4 <= {p4[2:0], rom_word(if4.rom_addr)};
  end
  assign if1.rom_rdata = v1[0] ? p1[0] : 'x;
  assign if4.rom_rdata = v4[3] ? p4[3] : 'x;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    tot_cnt++; if (if1.req_ready !== 1'b0) $display("FAIL reset_req_ready got %b expected 0", if1.req_ready); else pass_cnt++;
    tot_cnt++; if (if1.enc_valid !== 1'b0 || if1.rom_en !== 1'b0 || busy1 !== 1'b0) $display("FAIL reset_outputs got valid=%b en=%b busy=%b expected 0", if1.enc_valid, if1.rom_en, busy1); else pass_cnt++;
    tot_cnt++; if (if1.enc_data !== '0 || if1.enc_addr !== '0 || if1.enc_last !== 1'b0) $display("FAIL reset_enc got data=%h addr=%h last=%b expected 0", if1.enc_data, if1.enc_addr, if1.enc_last); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    tot_cnt++; if (if1.req_ready !== 1'b1 || if4.req_ready !== 1'b1) $display("FAIL post_reset_req_ready got %b/%b expected 1/1", if1.req_ready, if4.req_ready); else pass_cnt++;
  endtask
  task automatic test_single;
    if1.enc_ready = 1'b1;
    if1.req_addr  = 10'h005;
    if1.req_len   = 4'd0;
    if1.req_valid = 1'b1;
    tick();
    if1.req_valid = 1'b0;
    tot_cnt++; if (if1.rom_en !== 1'b1 || if1.rom_addr !== 10'h005 || if1.req_ready !== 1'b0) $display("FAIL single_issue got en=%b addr=%h rdy=%b expected 1/005/0", if1.rom_en, if1.rom_addr, if1.req_ready); else pass_cnt++;
    tick();
    tot_cnt++; if (if1.rom_en !== 1'b0 || if1.enc_valid !== 1'b0) $display("FAIL single_wait got en=%b valid=%b expected 0/0", if1.rom_en, if1.enc_valid); else pass_cnt++;
    tick();
    tot_cnt++; if (if1.enc_valid !== 1'b1 || if1.enc_data !== 39'h12_3456_789A || if1.enc_addr !== 10'h005 || if1.enc_last !== 1'b1) $display("FAIL single_data got valid=%b data=%h addr=%h last=%b expected 1/123456789a/005/1", if1.enc_valid, if1.enc_data, if1.enc_addr, if1.enc_last); else pass_cnt++;
    tick();
    tot_cnt++; if (if1.req_ready !== 1'b1 || if1.enc_valid !== 1'b0 || busy1 !== 1'b0) $display("FAIL single_done got rdy=%b valid=%b busy=%b expected 1/0/0", if1.req_ready, if1.enc_valid, busy1); else pass_cnt++;
  endtask
  task automatic test_burst_wrap;
    int ec[$];
    int vc[$];
    logic [9:0]  ea[$];
    logic [9:0]  eaddr[$];
    logic [38:0] ed[$];
    logic        el[$];
    logic [9:0]  exp_a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    if1.enc_ready = 1'b1;
    if1.req_addr  = 10'h3FE;
    if1.req_len   = 4'd3;
    if1.req_valid = 1'b1;
    tick();
    if1.req_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (if1.rom_en) begin
        ec.push_back(c);
        ea.push_back(if1.rom_addr);
      end
      if (if1.enc_valid) begin
        vc.push_back(c);
        ed.push_back(if1.enc_data);
        eaddr.push_back(if1.enc_addr);
        el.push_back(if1.enc_last);
      end
      tick();
    end
    tot_cnt++; if (ec.size() != 4 || vc.size() != 4) $display("FAIL burst_counts got en=%0d valid=%0d expected 4/4", ec.size(), vc.size()); else pass_cnt++;
    if (ec.size() == 4 && vc.size() == 4)
      for (int k = 0; k < 4; k++) begin
        tot_cnt++;
        if (ec[k] != 1 + 3 * k || ea[k] !== exp_a[k] || vc[k] != 3 + 3 * k || eaddr[k] !== exp_a[k] || ed[k] !== rom_word(exp_a[k]) || el[k] !== (k == 3))
          $display("FAIL burst_beat%0d got en_cyc=%0d addr=%h valid_cyc=%0d enc_addr=%h data=%h last=%b expected %0d/%h/%0d/%h/%h/%b", k, ec[k], ea[k], vc[k], eaddr[k], ed[k], el[k], 1 + 3 * k, exp_a[k], 3 + 3 * k, exp_a[k], rom_word(exp_a[k]), k == 3);
        else pass_cnt++;
      end
  endtask
  task automatic test_backpressure;
    int n = 0;
    bit stable = 1'b1;
    logic [38:0] d0;
    logic [9:0]  a0;
    logic        l0;
    if1.enc_ready = 1'b0;
    if1.req_addr  = 10'h010;
    if1.req_len   = 4'd2;
    if1.req_valid = 1'b1;
    tick();
    if1.req_valid = 1'b0;
    while (!if1.enc_valid && n < 10) begin
      tick();
      n++;
    end
    d0 = if1.enc_data;
    a0 = if1.enc_addr;
    l0 = if1.enc_last;
    tot_cnt++; if (if1.enc_valid !== 1'b1 || n != 2) $display("FAIL bp_first_valid got valid=%b after %0d cycles expected 1 after 2", if1.enc_valid, n); else pass_cnt++;
    tot_cnt++; if (d0 !== rom_word(10'h010) || a0 !== 10'h010 || l0 !== 1'b0) $display("FAIL bp_first_beat got data=%h addr=%h last=%b expected %h/010/0", d0, a0, l0, rom_word(10'h010)); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (if1.enc_valid !== 1'b1 || if1.enc_data !== d0 || if1.enc_addr !== a0 || if1.enc_last !== l0 || if1.rom_en !== 1'b0) stable = 1'b0;
    end
    tot_cnt++; if (stable !== 1'b1) $display("FAIL bp_hold_stable got %b expected 1", stable); else pass_cnt++;
    if1.enc_ready = 1'b1;
    tick();
    tot_cnt++; if (if1.rom_en !== 1'b1 || if1.rom_addr !== 10'h011 || if1.enc_valid !== 1'b0) $display("FAIL bp_resume got en=%b addr=%h valid=%b expected 1/011/0", if1.rom_en, if1.rom_addr, if1.enc_valid); else pass_cnt++;
    n = 0;
    while (busy1 && n < 20) begin
      tick();
      n++;
    end
    tot_cnt++; if (busy1 !== 1'b0) $display("FAIL bp_drain got busy=%b expected 0", busy1); else pass_cnt++;
  endtask
  task automatic test_lat4;
    bit xok = 1'b1;
    int vcyc = -1;
    logic [38:0] dv = '0;
    logic        lv = 1'b0;
    if4.enc_ready = 1'b1;
    if4.req_addr  = 10'h005;
    if4.req_len   = 4'd0;
    if4.req_valid = 1'b1;
    tick();
    if4.req_valid = 1'b0;
    tot_cnt++; if (if4.rom_en !== 1'b1 || if4.rom_addr !== 10'h005) $display("FAIL lat4_issue got en=%b addr=%h expected 1/005", if4.rom_en, if4.rom_addr); else pass_cnt++;
    for (int c = 1; c <= 8; c++) begin
      if ($isunknown(if4.enc_data)) xok = 1'b0;
      if (if4.enc_valid && vcyc < 0) begin
        vcyc = c;
        dv = if4.enc_data;
        lv = if4.enc_last;
      end
      tick();
    end
    tot_cnt++; if (vcyc != 6) $display("FAIL lat4_valid_cycle got %0d expected 6", vcyc); else pass_cnt++;
    tot_cnt++; if (dv !== 39'h12_3456_789A || lv !== 1'b1) $display("FAIL lat4_data got data=%h last=%b expected 123456789a/1", dv, lv); else pass_cnt++;
    tot_cnt++; if (xok !== 1'b1 || busy4 !== 1'b0) $display("FAIL lat4_no_x got xok=%b busy=%b expected 1/0", xok, busy4); else pass_cnt++;
  endtask
  task automatic test_busy_req;
    int acc = 0;
    int acc_cyc [2] = '{-1, -1};
    bit rdy_ok = 1'b1;
    logic [9:0] ea[$];
    if1.enc_ready = 1'b1;
    if1.req_addr  = 10'h020;
    if1.req_len   = 4'd1;
    if1.req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (acc == 1) begin
        if1.req_addr = 10'h100;
        if1.req_len  = 4'd0;
      end
      if (acc == 2) if1.req_valid = 1'b0;
      if (if1.req_valid && if1.req_ready && acc < 2) begin
        acc_cyc[acc] = c;
        acc++;
      end
      if (c >= 1 && c <= 6 && if1.req_ready) rdy_ok = 1'b0;
      if (if1.rom_en) ea.push_back(if1.rom_addr);
      tick();
    end
    if1.req_valid = 1'b0;
    tot_cnt++; if (acc != 2 || acc_cyc[0] != 0 || acc_cyc[1] != 7) $display("FAIL busy_accepts got n=%0d at %0d,%0d expected 2 at 0,7", acc, acc_cyc[0], acc_cyc[1]); else pass_cnt++;
    tot_cnt++; if (rdy_ok !== 1'b1) $display("FAIL busy_req_ready got %b expected 1", rdy_ok); else pass_cnt++;
    tot_cnt++; if (ea.size() != 3) $display("FAIL busy_rom_count got %0d expected 3", ea.size()); else pass_cnt++;
    if (ea.size() == 3) begin
      tot_cnt++; if (ea[0] !== 10'h020 || ea[1] !== 10'h021 || ea[2] !== 10'h100) $display("FAIL busy_rom_addrs got %h,%h,%h expected 020,021,100", ea[0], ea[1], ea[2]); else pass_cnt++;
    end
  endtask
  task automatic test_reset_mid;
    bit quiet = 1'b1;
    if1.enc_ready = 1'b1;
    if1.req_addr  = 10'h040;
    if1.req_len   = 4'd3;
    if1.req_valid = 1'b1;
    tick();
    if1.req_valid = 1'b0;
    tick();
    tick();
    tick();
    tot_cnt++; if (if1.rom_en !== 1'b1 || if1.rom_addr !== 10'h041) $display("FAIL rmid_beat2 got en=%b addr=%h expected 1/041", if1.rom_en, if1.rom_addr); else pass_cnt++;
    tick();
    tot_cnt++; if (busy1 !== 1'b1 || if1.enc_valid !== 1'b0) $display("FAIL rmid_wait got busy=%b valid=%b expected 1/0", busy1, if1.enc_valid); else pass_cnt++;
    rst_n = 1'b0;
    tick();
    tot_cnt++; if (if1.enc_valid !== 1'b0 || busy1 !== 1'b0 || if1.req_ready !== 1'b0) $display("FAIL rmid_reset got valid=%b busy=%b rdy=%b expected 0/0/0", if1.enc_valid, busy1, if1.req_ready); else pass_cnt++;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if1.rom_en !== 1'b0 || if1.enc_valid !== 1'b0 || busy1 !== 1'b0) quiet = 1'b0;
    end
    tot_cnt++; if (quiet !== 1'b1) $display("FAIL rmid_quiet got %b expected 1", quiet); else pass_cnt++;
    if1.req_addr  = 10'h3FF;
    if1.req_len   = 4'd0;
    if1.req_valid = 1'b1;
    tick();
    if1.req_valid = 1'b0;
    tick();
    tick();
    tot_cnt++; if (if1.enc_valid !== 1'b1 || if1.enc_data !== rom_word(10'h3FF) || if1.enc_addr !== 10'h3FF || if1.enc_last !== 1'b1) $display("FAIL rmid_fresh got valid=%b data=%h addr=%h last=%b expected 1/%h/3ff/1", if1.enc_valid, if1.enc_data, if1.enc_addr, if1.enc_last, rom_word(10'h3FF)); else pass_cnt++;
    tick();
  endtask
  initial begin
    if1.req_valid = 1'b0; if1.req_addr = '0; if1.req_len = '0; if1.enc_ready = 1'b0;
    if4.req_valid = 1'b0; if4.req_addr = '0; if4.req_len = '0; if4.enc_ready = 1'b0;
    test_reset();
    test_single();
    test_burst_wrap();
    test_backpressure();
    test_lat4();
    test_busy_req();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d/%0d checks", pass_cnt, tot_cnt);
    $fatal(1, "timeout");
  end
endmodule
